// File: rtl/id_ex_stage.sv
// ID/EX pipeline boundary: WB bypass into captured operands, load-use
// hazard detection with bubble insertion, and EX-flush squash.
module id_ex_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic            id_uses_rs1,
    input  logic            id_uses_rs2,
    input  logic [XLEN-1:0] read_data1,
    input  logic [XLEN-1:0] read_data2,
    input  logic [XLEN-1:0] id_imm,
    input  logic            id_RegWrite,
    input  logic            id_MemRead,
    input  logic            id_MemWrite,
    input  logic            id_MemToReg,
    input  logic            id_ALUSrc,
    input  logic            id_Branch,
    input  logic [3:0]      id_ALUOp,
    input  logic            wb_RegWrite,
    input  logic [4:0]      wb_Rd,
    input  logic [XLEN-1:0] wb_Write_data,
    input  logic            flush_ex,
    output logic            stall,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic            ex_RegWrite,
    output logic            ex_MemRead,
    output logic            ex_MemWrite,
    output logic            ex_MemToReg,
    output logic            ex_ALUSrc,
    output logic            ex_Branch,
    output logic [3:0]      ex_ALUOp,
    output logic [31:0]     bubble_count
);

    localparam int unsigned REGW   = 5;
    localparam int unsigned ALUOPW = 4;
    localparam int unsigned CNTW   = 32;

    logic              w_hazard;
    logic              w_byp1;
    logic              w_byp2;
    logic [XLEN-1:0]   w_op1;
    logic [XLEN-1:0]   w_op2;

    logic              r_valid;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_rs1_data;
    logic [XLEN-1:0]   r_rs2_data;
    logic [XLEN-1:0]   r_imm;
    logic [REGW-1:0]   r_rs1;
    logic [REGW-1:0]   r_rs2;
    logic [REGW-1:0]   r_rd;
    logic              r_regwrite;
    logic              r_memread;
    logic              r_memwrite;
    logic              r_memtoreg;
    logic              r_alusrc;
    logic              r_branch;
    logic [ALUOPW-1:0] r_aluop;
    logic [CNTW-1:0]   r_bubble_count;

    // Load-use hazard detection and same-cycle writeback bypass.
    always_comb begin
        w_hazard = 1'b0;
        w_byp1   = 1'b0;
        w_byp2   = 1'b0;
        w_op1    = read_data1;
        w_op2    = read_data2;
        if (r_valid && r_memread && (r_rd != REGW'(0)) && id_valid) begin
            w_hazard = (id_uses_rs1 && (id_rs1 == r_rd)) ||
                       (id_uses_rs2 && (id_rs2 == r_rd));
        end
        w_byp1 = wb_RegWrite && (wb_Rd != REGW'(0)) && (wb_Rd == id_rs1);
        w_byp2 = wb_RegWrite && (wb_Rd != REGW'(0)) && (wb_Rd == id_rs2);
        if (w_byp1) w_op1 = wb_Write_data;
        if (w_byp2) w_op2 = wb_Write_data;
    end

    // EX register update: reset, then flush bubble, then hazard bubble, else capture.
    always_ff @(posedge clk) begin
        if (reset || flush_ex || w_hazard) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_alusrc   <= 1'b0;
            r_branch   <= 1'b0;
            r_aluop    <= '0;
        end else begin
            r_valid    <= id_valid;
            r_pc       <= id_pc;
            r_rs1_data <= w_op1;
            r_rs2_data <= w_op2;
            r_imm      <= id_imm;
            r_rs1      <= id_rs1;
            r_rs2      <= id_rs2;
            r_rd       <= id_rd;
            r_regwrite <= id_valid && id_RegWrite;
            r_memread  <= id_valid && id_MemRead;
            r_memwrite <= id_valid && id_MemWrite;
            r_memtoreg <= id_valid && id_MemToReg;
            r_alusrc   <= id_valid && id_ALUSrc;
            r_branch   <= id_valid && id_Branch;
            r_aluop    <= id_valid ? id_ALUOp : ALUOPW'(0);
        end
    end

    // Saturating count of load-use bubbles; flush bubbles are not counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bubble_count <= '0;
        end else if (!flush_ex && w_hazard && (r_bubble_count != '1)) begin
            r_bubble_count <= r_bubble_count + CNTW'(1);
        end
    end

    assign stall        = w_hazard && !flush_ex;
    assign ex_valid     = r_valid;
    assign ex_pc        = r_pc;
    assign ex_rs1_data  = r_rs1_data;
    assign ex_rs2_data  = r_rs2_data;
    assign ex_imm       = r_imm;
    assign ex_rs1       = r_rs1;
    assign ex_rs2       = r_rs2;
    assign ex_rd        = r_rd;
    assign ex_RegWrite  = r_regwrite;
    assign ex_MemRead   = r_memread;
    assign ex_MemWrite  = r_memwrite;
    assign ex_MemToReg  = r_memtoreg;
    assign ex_ALUSrc    = r_alusrc;
    assign ex_Branch    = r_branch;
    assign ex_ALUOp     = r_aluop;
    assign bubble_count = r_bubble_count;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vectors with literal expectations plus a
// behavioural EX-slot model checked every cycle.
module tb_id_ex_stage;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [4:0]      id_rs1, id_rs2, id_rd;
    logic            id_uses_rs1, id_uses_rs2;
    logic [XLEN-1:0] read_data1, read_data2, id_imm;
    logic            id_RegWrite, id_MemRead, id_MemWrite, id_MemToReg, id_ALUSrc, id_Branch;
    logic [3:0]      id_ALUOp;
    logic            wb_RegWrite;
    logic [4:0]      wb_Rd;
    logic [XLEN-1:0] wb_Write_data;
    logic            flush_ex;
    logic            stall;
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]      ex_rs1, ex_rs2, ex_rd;
    logic            ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemToReg, ex_ALUSrc, ex_Branch;
    logic [3:0]      ex_ALUOp;
    logic [31:0]     bubble_count;

    int n_checks = 0;
    int n_errors = 0;

    id_ex_stage #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .read_data1(read_data1), .read_data2(read_data2), .id_imm(id_imm),
        .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
        .id_MemToReg(id_MemToReg), .id_ALUSrc(id_ALUSrc), .id_Branch(id_Branch),
        .id_ALUOp(id_ALUOp), .wb_RegWrite(wb_RegWrite), .wb_Rd(wb_Rd),
        .wb_Write_data(wb_Write_data), .flush_ex(flush_ex), .stall(stall),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead),
        .ex_MemWrite(ex_MemWrite), .ex_MemToReg(ex_MemToReg), .ex_ALUSrc(ex_ALUSrc),
        .ex_Branch(ex_Branch), .ex_ALUOp(ex_ALUOp), .bubble_count(bubble_count)
    );

    always #5 clk = ~clk;

    // Model of the EX slot: one record, an all-zero record is a bubble.
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc, rs1_data, rs2_data, imm;
        logic [4:0]      rs1, rs2, rd;
        logic            regwrite, memread, memwrite, memtoreg, alusrc, branch;
        logic [3:0]      aluop;
    } ex_t;

    ex_t         exp_ex;
    logic [31:0] exp_cnt;
    bit          model_ok = 1'b0;
    ex_t         dut_ex;

    assign dut_ex = {ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
                     ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemToReg, ex_ALUSrc, ex_Branch,
                     ex_ALUOp};

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Value that register r holds once this cycle's writeback has landed.
    function automatic logic [XLEN-1:0] reg_value(input logic [4:0] r, input logic [XLEN-1:0] rf);
        if (r != 5'd0 && wb_RegWrite && wb_Rd == r) return wb_Write_data;
        return rf;
    endfunction

    // Would the ID instruction consume the value the EX load has not produced yet?
    function automatic bit load_use();
        bit reads_rd;
        reads_rd = (id_uses_rs1 && id_rs1 == exp_ex.rd) || (id_uses_rs2 && id_rs2 == exp_ex.rd);
        return exp_ex.valid && exp_ex.memread && exp_ex.rd != 5'd0 && id_valid && reads_rd;
    endfunction

    // Advance the model on each rising edge.
    always @(posedge clk) begin
        if (reset) begin
            exp_ex   = '0;
            exp_cnt  = 32'd0;
            model_ok = 1'b1;
        end else if (flush_ex) begin
            exp_ex = '0;
        end else if (load_use()) begin
            exp_ex = '0;
            if (exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
        end else begin
            exp_ex.valid    = id_valid;
            exp_ex.pc       = id_pc;
            exp_ex.rs1_data = reg_value(id_rs1, read_data1);
            exp_ex.rs2_data = reg_value(id_rs2, read_data2);
            exp_ex.imm      = id_imm;
            exp_ex.rs1      = id_rs1;
            exp_ex.rs2      = id_rs2;
            exp_ex.rd       = id_rd;
            exp_ex.regwrite = id_valid & id_RegWrite;
            exp_ex.memread  = id_valid & id_MemRead;
            exp_ex.memwrite = id_valid & id_MemWrite;
            exp_ex.memtoreg = id_valid & id_MemToReg;
            exp_ex.alusrc   = id_valid & id_ALUSrc;
            exp_ex.branch   = id_valid & id_Branch;
            exp_ex.aluop    = id_valid ? id_ALUOp : 4'd0;
        end
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (model_ok) begin
            check("ex_slot", 256'(dut_ex), 256'(exp_ex));
            check("bubble_count", 256'(bubble_count), 256'(exp_cnt));
            check("stall", 256'(stall), 256'(load_use() && !flush_ex));
        end
    end

    task automatic idle();
        id_valid = 0; id_pc = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_uses_rs1 = 0; id_uses_rs2 = 0; read_data1 = '0; read_data2 = '0; id_imm = '0;
        id_RegWrite = 0; id_MemRead = 0; id_MemWrite = 0; id_MemToReg = 0;
        id_ALUSrc = 0; id_Branch = 0; id_ALUOp = '0;
        wb_RegWrite = 0; wb_Rd = '0; wb_Write_data = '0; flush_ex = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic issue_load(input logic [4:0] rd);
        idle();
        id_valid = 1; id_rd = rd; id_rs1 = 5'd6; id_uses_rs1 = 1;
        id_MemRead = 1; id_RegWrite = 1; id_MemToReg = 1; id_ALUSrc = 1;
        next_cycle();
    endtask

    initial begin
        idle();
        reset = 1;
        next_cycle();
        reset = 0;
        #1;
        check("reset ex_valid", 256'(ex_valid), 256'(0));
        check("reset ex_pc", 256'(ex_pc), 256'(0));
        check("reset bubble_count", 256'(bubble_count), 256'(0));
        check("reset stall", 256'(stall), 256'(0));

        // Plain capture
        id_valid = 1; id_pc = 32'h100; id_rs1 = 5'd1; id_uses_rs1 = 1; id_rd = 5'd2;
        read_data1 = 32'hA5A5_A5A5; id_imm = 32'h10; id_RegWrite = 1; id_ALUOp = 4'h2;
        next_cycle();
        check("cap ex_pc", 256'(ex_pc), 256'(32'h100));
        check("cap ex_rs1_data", 256'(ex_rs1_data), 256'(32'hA5A5_A5A5));
        check("cap ex_imm", 256'(ex_imm), 256'(32'h10));
        check("cap ex_RegWrite", 256'(ex_RegWrite), 256'(1));
        check("cap ex_valid", 256'(ex_valid), 256'(1));

        // WB bypass on rs2, rs1 untouched
        idle();
        id_valid = 1; id_rs1 = 5'd4; read_data1 = 32'h1111; id_rs2 = 5'd3; id_uses_rs2 = 1;
        wb_RegWrite = 1; wb_Rd = 5'd3; wb_Write_data = 32'hDEAD_BEEF;
        next_cycle();
        check("byp ex_rs2_data", 256'(ex_rs2_data), 256'(32'hDEAD_BEEF));
        check("byp ex_rs1_data", 256'(ex_rs1_data), 256'(32'h1111));

        // x0 never bypasses
        idle();
        id_valid = 1; id_rs2 = 5'd0; id_uses_rs2 = 1;
        wb_RegWrite = 1; wb_Rd = 5'd0; wb_Write_data = 32'hDEAD_BEEF;
        next_cycle();
        check("x0 ex_rs2_data", 256'(ex_rs2_data), 256'(0));

        // Load-use: one bubble, then the held instruction is captured
        issue_load(5'd5);
        idle();
        id_valid = 1; id_pc = 32'h200; id_rs1 = 5'd5; id_uses_rs1 = 1; id_rd = 5'd7;
        id_RegWrite = 1; read_data1 = 32'h55;
        #1;
        check("lu stall", 256'(stall), 256'(1));
        next_cycle();
        check("lu bubble ex_valid", 256'(ex_valid), 256'(0));
        check("lu bubble ex_RegWrite", 256'(ex_RegWrite), 256'(0));
        check("lu bubble_count", 256'(bubble_count), 256'(1));
        #1;
        check("lu stall drop", 256'(stall), 256'(0));
        next_cycle();
        check("lu held ex_valid", 256'(ex_valid), 256'(1));
        check("lu held ex_pc", 256'(ex_pc), 256'(32'h200));
        check("lu held ex_rd", 256'(ex_rd), 256'(7));

        // Load to x0: no hazard
        issue_load(5'd0);
        idle();
        id_valid = 1; id_rs1 = 5'd0; id_uses_rs1 = 1;
        #1;
        check("ld x0 stall", 256'(stall), 256'(0));
        next_cycle();
        check("ld x0 ex_valid", 256'(ex_valid), 256'(1));

        // rs2 matches but is not read: no hazard
        issue_load(5'd8);
        idle();
        id_valid = 1; id_rs1 = 5'd9; id_uses_rs1 = 1; id_rs2 = 5'd8; id_uses_rs2 = 0;
        #1;
        check("no-use stall", 256'(stall), 256'(0));
        next_cycle();
        check("no-use bubble_count", 256'(bubble_count), 256'(1));

        // Flush beats hazard
        issue_load(5'd10);
        idle();
        id_valid = 1; id_rs1 = 5'd10; id_uses_rs1 = 1; id_RegWrite = 1; flush_ex = 1;
        #1;
        check("flush stall", 256'(stall), 256'(0));
        next_cycle();
        check("flush ex_valid", 256'(ex_valid), 256'(0));
        check("flush ex_RegWrite", 256'(ex_RegWrite), 256'(0));
        check("flush bubble_count", 256'(bubble_count), 256'(1));

        // Invalid ID: control bits captured as zero
        idle();
        id_RegWrite = 1; id_MemWrite = 1; id_Branch = 1; id_pc = 32'h300;
        next_cycle();
        check("inv ex_RegWrite", 256'(ex_RegWrite), 256'(0));
        check("inv ex_MemWrite", 256'(ex_MemWrite), 256'(0));

        // Reset mid-stall
        issue_load(5'd11);
        idle();
        id_valid = 1; id_rs2 = 5'd11; id_uses_rs2 = 1;
        #1;
        check("rst-stall stall", 256'(stall), 256'(1));
        reset = 1;
        next_cycle();
        reset = 0;
        idle();
        #1;
        check("rst-stall ex_valid", 256'(ex_valid), 256'(0));
        check("rst-stall stall0", 256'(stall), 256'(0));
        check("rst-stall bubble_count", 256'(bubble_count), 256'(0));

        // Mixed traffic with small register indices, checked by the model
        for (int i = 0; i < 300; i++) begin
            id_valid      = 1'($urandom_range(0, 3) != 0);
            id_pc         = $urandom;
            id_rs1        = 5'($urandom_range(0, 3));
            id_rs2        = 5'($urandom_range(0, 3));
            id_rd         = 5'($urandom_range(0, 3));
            id_uses_rs1   = 1'($urandom_range(0, 1));
            id_uses_rs2   = 1'($urandom_range(0, 1));
            read_data1    = $urandom;
            read_data2    = $urandom;
            id_imm        = $urandom;
            id_RegWrite   = 1'($urandom_range(0, 1));
            id_MemRead    = 1'($urandom_range(0, 1));
            id_MemWrite   = 1'($urandom_range(0, 1));
            id_MemToReg   = 1'($urandom_range(0, 1));
            id_ALUSrc     = 1'($urandom_range(0, 1));
            id_Branch     = 1'($urandom_range(0, 1));
            id_ALUOp      = 4'($urandom_range(0, 15));
            wb_RegWrite   = 1'($urandom_range(0, 1));
            wb_Rd         = 5'($urandom_range(0, 3));
            wb_Write_data = $urandom;
            flush_ex      = ($urandom_range(0, 7) == 0);
            next_cycle();
        end

        idle();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
